// File: rtl/ro_meter_pkg.sv
// ro_meter_pkg: state encoding and helpers shared by the
// ring-oscillator frequency meter.
package ro_meter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_STRESS  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_SETTLE  = ST_SETTLE,
        S_MEASURE = ST_MEASURE,
        S_DONE    = ST_DONE,
        S_STRESS  = ST_STRESS
    } ro_state_t;

    function automatic int unsigned clamp_ch(
        input int unsigned sel,
        input int unsigned num_ch
    );
        return (sel >= num_ch) ? num_ch - 1 : sel;
    endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: two-flop synchroniser for one oscillator output
// followed by a rising-edge detector in the clk domain.
module ro_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ro_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= ro_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: multi-channel ring-oscillator frequency meter with
// settle, windowed edge counting, continuous mode and stress control.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int CNT_W      = 16,
    parameter  int WIN_W      = 16,
    parameter  int SETTLE_CYC = 8,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ro_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              stress,
    output logic [NUM_CH-1:0] ro_en,
    output logic              ro_stress,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              valid
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYC - 1);

    ro_state_t         state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              cont_q, cont_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              valid_q;
    logic              busy_q;
    logic              stress_q;
    logic [NUM_CH-1:0] en_q, en_d;

    logic [NUM_CH-1:0] pulse_v;
    logic              pulse;
    logic              sat_hit;
    logic [CNT_W-1:0]  cnt_nxt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        ro_sync_edge u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .ro_i    (ro_in[g]),
            .pulse_o (pulse_v[g])
        );
    end

    assign pulse   = pulse_v[ch_q];
    assign sat_hit = pulse && (cnt_q == '1);
    assign cnt_nxt = (pulse && !sat_hit) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        win_d   = win_q;
        cont_d  = cont_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                acc_d = 1'b0;
                if (start && (win_len != '0)) begin
                    state_d = S_SETTLE;
                    ch_d    = CH_W'(clamp_ch(32'(ch_sel), NUM_CH));
                    win_d   = win_len;
                    cont_d  = cont;
                    tmr_d   = SET_LOAD;
                end else if (!start && stress) begin
                    state_d = S_STRESS;
                end
            end
            S_SETTLE: begin
                cnt_d = '0;
                acc_d = 1'b0;
                if (tmr_q == '0) begin
                    state_d = S_MEASURE;
                    tmr_d   = TMR_W'(win_q) - 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_MEASURE: begin
                cnt_d = cnt_nxt;
                acc_d = acc_q | sat_hit;
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                    count_d = cnt_nxt;
                    ovf_d   = acc_q | sat_hit;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                acc_d = 1'b0;
                if (cont_q) begin
                    state_d = S_MEASURE;
                    tmr_d   = TMR_W'(win_q) - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STRESS: begin
                if (!stress) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins even on the last MEASURE cycle: no result is published
        if (abort) begin
            state_d = S_IDLE;
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    always_comb begin
        en_d = '0;
        unique case (state_d)
            S_IDLE:   en_d = '0;
            S_STRESS: en_d = '1;
            default:  en_d = NUM_CH'(1) << ch_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            win_q    <= '0;
            cont_q   <= 1'b0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            stress_q <= 1'b0;
            en_q     <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            win_q    <= win_d;
            cont_q   <= cont_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            valid_q  <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE);
            stress_q <= (state_d == S_STRESS);
            en_q     <= en_d;
        end
    end

    assign ro_en     = en_q;
    assign ro_stress = stress_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: table vectors, corner sequences and random waves
// checked against an edge-counting model over the sampled inputs.
module tb_ro_freq_meter;

    localparam int SET = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ro_in;
    logic [1:0]  ch_sel;
    logic [15:0] win_len;
    logic        start, cont, abort, stress;

    logic [3:0]  ro_en;
    logic        ro_stress, busy, ovf, valid;
    logic [15:0] count;
    logic [2:0]  ro_en_s;
    logic        ro_stress_s, busy_s, ovf_s, valid_s;
    logic [3:0]  count_s;

    ro_freq_meter #(.NUM_CH(4), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(SET)) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ch_sel(ch_sel),
        .win_len(win_len), .start(start), .cont(cont), .abort(abort),
        .stress(stress), .ro_en(ro_en), .ro_stress(ro_stress),
        .busy(busy), .count(count), .ovf(ovf), .valid(valid)
    );

    // narrow counter and three channels: saturation and channel clamping
    ro_freq_meter #(.NUM_CH(3), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(SET)) dut_s (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in[2:0]), .ch_sel(ch_sel),
        .win_len(win_len), .start(start), .cont(cont), .abort(abort),
        .stress(stress), .ro_en(ro_en_s), .ro_stress(ro_stress_s),
        .busy(busy_s), .count(count_s), .ovf(ovf_s), .valid(valid_s)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int nval = 0;
    int cyc  = 0;
    int per [4];
    int hi  [4];
    int ph  [4];
    logic [3:0] samp [0:99999];

    always @(posedge clk) begin
        cyc = cyc + 1;
        samp[cyc] = ro_in;
    end

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++)
            ro_in[c] = (((cyc + ph[c]) % per[c]) < hi[c]);
    end

    always @(negedge clk) if (valid === 1'b1) nval++;

    typedef struct {
        logic [1:0] ch;
        int         w;
        int         p0, p1, p2, p3;
        int         cnt;
        bit         ov;
        int         cnt_s;
        bit         ov_s;
        logic [3:0] en;
        logic [2:0] en_s;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // a rise is counted at edge t when its pulse is live, i.e. the
    // input was low at edge t-3 and high at edge t-2
    function automatic int raw_edges(int s, int w, int ch);
        int n = 0;
        for (int t = s + SET + 1; t <= s + SET + w; t++)
            if (samp[t-2][ch] && !samp[t-3][ch]) n++;
        return n;
    endfunction

    task automatic set_waves(int a, int b, int c, int d);
        per[0] = a; per[1] = b; per[2] = c; per[3] = d;
        for (int i = 0; i < 4; i++) begin
            hi[i] = per[i] / 2;
            ph[i] = 0;
        end
    endtask

    task automatic kick(input logic [1:0] ch, input int w, input bit c,
                        output int s);
        @(negedge clk);
        ch_sel  = ch;
        win_len = 16'(w);
        cont    = c;
        start   = 1'b1;
        @(posedge clk);
        #1;
        s     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL valid_timeout: no strobe within %0d cycles", lim);
        end
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_ro_en"}, ro_en, 0);
        chk({nm, "_ro_en_s"}, ro_en_s, 0);
        chk({nm, "_stress"}, ro_stress, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, valid, 0);
    endtask

    initial begin
        int s, at, prev, nv, rs, ch, chs, w;
        bit ok;

        set_waves(2, 4, 6, 3);
        ro_in = '0; rst_n = 1'b0;
        ch_sel = '0; win_len = '0;
        start = 0; cont = 0; abort = 0; stress = 0;

        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count_s", count_s, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");

        tbl[0] = '{2'd1, 100, 2, 4, 6, 3, 25, 0, 15, 1, 4'b0010, 3'b010};
        tbl[1] = '{2'd0, 100, 2, 4, 6, 3, 50, 0, 15, 1, 4'b0001, 3'b001};
        tbl[2] = '{2'd3,  60, 2, 4, 6, 3, 20, 0, 10, 0, 4'b1000, 3'b100};
        tbl[3] = '{2'd2,  12, 2, 4, 6, 3,  2, 0,  2, 0, 4'b0100, 3'b100};
        tbl[4] = '{2'd0,  30, 2, 4, 6, 3, 15, 0, 15, 0, 4'b0001, 3'b001};
        tbl[5] = '{2'd0,  32, 2, 4, 6, 3, 16, 0, 15, 1, 4'b0001, 3'b001};

        for (int i = 0; i < 6; i++) begin
            set_waves(tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3);
            kick(tbl[i].ch, tbl[i].w, 1'b0, s);
            repeat (12) @(negedge clk);
            chk("tbl_ro_en", ro_en, tbl[i].en);
            chk("tbl_ro_en_s", ro_en_s, tbl[i].en_s);
            chk("tbl_busy", busy, 1);
            wait_valid(tbl[i].w + SET + 20, at, ok);
            if (ok) begin
                chk("tbl_latency", at - s, SET + tbl[i].w);
                chk("tbl_count", count, tbl[i].cnt);
                chk("tbl_ovf", ovf, tbl[i].ov);
                chk("tbl_valid_s", valid_s, 1);
                chk("tbl_count_s", count_s, tbl[i].cnt_s);
                chk("tbl_ovf_s", ovf_s, tbl[i].ov_s);
            end
            @(negedge clk);
            chk_idle("tbl_after");
        end

        set_waves(2, 4, 6, 3);
        @(negedge clk);
        #1 nv = nval;
        kick(2'd1, 0, 1'b0, s);
        @(negedge clk);
        chk("zero_win_busy", busy, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("zero_win_busy_later", busy, 0);
        chk("zero_win_no_valid", nval, nv);

        kick(2'd1, 100, 1'b0, s);
        repeat (20) @(negedge clk);
        ch_sel = 2'd0; win_len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(150, at, ok);
        if (ok) begin
            chk("busy_start_latency", at - s, SET + 100);
            chk("busy_start_count", count, 25);
        end

        kick(2'd1, 20, 1'b1, s);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(60, at, ok);
            if (ok) begin
                chk("cont_count", count, 5);
                chk("cont_count_s", count_s, 5);
                chk("cont_ovf", ovf, 0);
                if (k == 0) chk("cont_first", at - s, SET + 20);
                else chk("cont_interval", at - prev, 21);
                prev = at;
            end
            @(negedge clk);
            chk("cont_ro_en", ro_en, 4'b0010);
            chk("cont_busy", busy, 1);
        end
        pulse_abort();
        @(negedge clk);
        chk("cont_abort_busy", busy, 0);
        chk("cont_abort_ro_en", ro_en, 0);
        #1 nv = nval;
        repeat (60) @(negedge clk);
        #1;
        chk("cont_abort_no_valid", nval, nv);
        chk("cont_abort_count", count, 5);
        cont = 1'b0;

        @(negedge clk);
        stress = 1'b1;
        @(negedge clk);
        chk("stress_ro_en", ro_en, 4'b1111);
        chk("stress_ro_en_s", ro_en_s, 3'b111);
        chk("stress_out", ro_stress, 1);
        chk("stress_busy", busy, 1);
        ch_sel = 2'd1; win_len = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("stress_start_ignored", ro_en, 4'b1111);
        stress = 1'b0;
        @(negedge clk);
        chk_idle("stress_exit");

        kick(2'd1, 100, 1'b0, s);
        wait_valid(150, at, ok);
        if (ok) chk("pre_abort_count", count, 25);
        kick(2'd1, 100, 1'b0, s);
        repeat (50) @(negedge clk);
        #1 nv = nval;
        pulse_abort();
        repeat (150) @(negedge clk);
        #1;
        chk("abort_no_valid", nval, nv);
        chk("abort_count", count, 25);
        chk("abort_busy", busy, 0);

        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 4; c++) begin
                per[c] = $urandom_range(9, 2);
                hi[c]  = $urandom_range(per[c] - 1, 1);
                ph[c]  = $urandom_range(8, 0);
            end
            ch = $urandom_range(3, 0);
            chs = (ch >= 3) ? 2 : ch;
            w = (i % 4 == 0) ? $urandom_range(300, 100)
                             : $urandom_range(40, 1);
            kick(2'(ch), w, 1'b0, s);
            wait_valid(w + SET + 20, at, ok);
            if (ok) begin
                rs = raw_edges(s, w, ch);
                chk("rnd_latency", at - s, SET + w);
                chk("rnd_count", count, rs);
                chk("rnd_ovf", ovf, 0);
                rs = raw_edges(s, w, chs);
                chk("rnd_count_s", count_s, (rs > 15) ? 15 : rs);
                chk("rnd_ovf_s", ovf_s, (rs > 15) ? 1 : 0);
            end
            @(negedge clk);
        end

        ch = $urandom_range(3, 0);
        w = $urandom_range(30, 5);
        kick(2'(ch), w, 1'b1, s);
        for (int k = 0; k < 3; k++) begin
            wait_valid(w + SET + 20, at, ok);
            if (ok) begin
                chk("rnd_cont_at", at - s, SET + w + k * (w + 1));
                chk("rnd_cont_count", count,
                    raw_edges(s + k * (w + 1), w, ch));
            end
        end
        pulse_abort();
        cont = 1'b0;
        @(negedge clk);
        chk("rnd_cont_abort", busy, 0);

        set_waves(2, 4, 6, 3);
        kick(2'd1, 100, 1'b0, s);
        repeat (40) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_count_s", count_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_mid_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
